pll_reset_sequencer: RTL and testbench

- Sequences the system PLL clock block from the free-running 24 MHz reference clock domain.
- Pulses the PLL reset, waits for lock, and qualifies lock over a settle window before releasing the system reset.
- Supervises the running PLL and re-sequences it on lock loss or on a stalled output-clock heartbeat.
- Sits beside the PLL wrapper at the top level; its outputs drive the PLL reset pin and the global system reset request.

---
 rtl/pll_seq_pkg.sv | 17 +
 rtl/sync_bit.sv | 27 ++
 rtl/pll_reset_sequencer.sv | 176 +++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encoding and
// the retry-counter saturation limit helper.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    SETTLE    = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  // All-ones value of a retry counter of the given width.
  function automatic int retry_max(input int width);
    return (32'sd1 <<< width) - 32'sd1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single bit into the refclk domain.
// q is the last stage; tap is the stage before it, for edge detection.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic tap
);

  logic [STAGES-1:0] chain_r;

  // Shift chain; reset clears every stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain_r <= {STAGES{1'b0}};
    end else begin
      chain_r <= {chain_r[STAGES-2:0], d};
    end
  end

  assign q   = chain_r[STAGES-1];
  assign tap = chain_r[STAGES-2];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulse PLL reset, wait for and qualify lock, then release
// system reset. Heartbeat watchdog is built only with PLL_HEARTBEAT_WATCHDOG_EN.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RESET_CYCLES    = 24,
  parameter int LOCK_TIMEOUT    = 24000,
  parameter int SETTLE_CYCLES   = 2400,
  parameter int WATCHDOG_CYCLES = 64,
  parameter int CNT_WIDTH       = 16,
  parameter int RETRY_WIDTH     = 4
) (
  input  logic                   refclk,
  input  logic                   reset,
  input  logic                   restart,
  input  logic                   pll_lock,
  input  logic                   heartbeat,
  output logic                   pll_reset,
  output logic                   sys_reset,
  output logic                   ready,
  output logic [RETRY_WIDTH-1:0] retry_count,
  output logic                   fault
);

  localparam logic [RETRY_WIDTH-1:0] RETRY_MAX = RETRY_WIDTH'(retry_max(RETRY_WIDTH));

  seq_state_e             state_r;
  seq_state_e             state_nxt_s;
  logic [CNT_WIDTH-1:0]   cnt_r;
  logic [CNT_WIDTH-1:0]   cnt_nxt_s;
  logic [RETRY_WIDTH-1:0] retry_nxt_s;
  logic [RETRY_WIDTH-1:0] retry_inc_s;
  logic                   fault_nxt_s;
  logic                   fail_s;
  logic                   lock_s;
  logic                   unused_lock_tap;
  logic                   wd_expired_s;

  sync_bit #(.STAGES(2)) u_lock_sync (
    .clk   (refclk),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s),
    .tap   (unused_lock_tap)
  );

`ifdef PLL_HEARTBEAT_WATCHDOG_EN
  logic                 hb_q_s;
  logic                 hb_tap_s;
  logic                 hb_edge_s;
  logic [CNT_WIDTH-1:0] wd_r;

  sync_bit #(.STAGES(3)) u_hb_sync (
    .clk   (refclk),
    .reset (reset),
    .d     (heartbeat),
    .q     (hb_q_s),
    .tap   (hb_tap_s)
  );

  assign hb_edge_s    = hb_tap_s ^ hb_q_s;
  assign wd_expired_s = (state_r == RUN) && !hb_edge_s &&
                        (wd_r == CNT_WIDTH'(WATCHDOG_CYCLES - 1));

  // Watchdog counts quiet RUN cycles; held at zero outside RUN so entry starts fresh.
  always_ff @(posedge refclk) begin
    if (reset) begin
      wd_r <= {CNT_WIDTH{1'b0}};
    end else if (state_r != RUN || hb_edge_s) begin
      wd_r <= {CNT_WIDTH{1'b0}};
    end else if (wd_r != CNT_WIDTH'(WATCHDOG_CYCLES - 1)) begin
      wd_r <= wd_r + CNT_WIDTH'(1);
    end else begin
      wd_r <= wd_r;
    end
  end
`else
  logic        unused_hb;
  logic [31:0] unused_wd_cfg;

  assign unused_hb     = heartbeat;
  assign unused_wd_cfg = 32'(WATCHDOG_CYCLES);
  assign wd_expired_s  = 1'b0;
`endif

  assign retry_inc_s = (retry_count == RETRY_MAX) ? RETRY_MAX : retry_count + RETRY_WIDTH'(1);

  // Next-state, phase counter and retry bookkeeping.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    retry_nxt_s = retry_count;
    fault_nxt_s = fault;
    fail_s      = 1'b0;
    if (restart) begin
      state_nxt_s = RESET_PLL;
      cnt_nxt_s   = {CNT_WIDTH{1'b0}};
      retry_nxt_s = {RETRY_WIDTH{1'b0}};
      fault_nxt_s = 1'b0;
    end else begin
      case (state_r)
        RESET_PLL: begin
          if (cnt_r == CNT_WIDTH'(RESET_CYCLES - 1)) begin
            state_nxt_s = WAIT_LOCK;
            cnt_nxt_s   = {CNT_WIDTH{1'b0}};
          end else begin
            cnt_nxt_s = cnt_r + CNT_WIDTH'(1);
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_nxt_s = SETTLE;
            cnt_nxt_s   = {CNT_WIDTH{1'b0}};
          end else if (cnt_r == CNT_WIDTH'(LOCK_TIMEOUT - 1)) begin
            fail_s = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + CNT_WIDTH'(1);
          end
        end
        SETTLE: begin
          if (!lock_s) begin
            state_nxt_s = WAIT_LOCK;
            cnt_nxt_s   = {CNT_WIDTH{1'b0}};
          end else if (cnt_r == CNT_WIDTH'(SETTLE_CYCLES - 1)) begin
            state_nxt_s = RUN;
            cnt_nxt_s   = {CNT_WIDTH{1'b0}};
          end else begin
            cnt_nxt_s = cnt_r + CNT_WIDTH'(1);
          end
        end
        RUN: begin
          if (!lock_s || wd_expired_s) begin
            fail_s = 1'b1;
          end else begin
            state_nxt_s = RUN;
          end
        end
        default: begin
          state_nxt_s = RESET_PLL;
          cnt_nxt_s   = {CNT_WIDTH{1'b0}};
        end
      endcase
    end
    // A failed attempt re-pulses the PLL and counts toward the sticky fault.
    if (fail_s) begin
      state_nxt_s = RESET_PLL;
      cnt_nxt_s   = {CNT_WIDTH{1'b0}};
      retry_nxt_s = retry_inc_s;
      fault_nxt_s = fault | (retry_inc_s == RETRY_MAX);
    end else begin
      fail_s = 1'b0;
    end
  end

  // State, counters and registered output decode.
  always_ff @(posedge refclk) begin
    if (reset) begin
      state_r     <= RESET_PLL;
      cnt_r       <= {CNT_WIDTH{1'b0}};
      retry_count <= {RETRY_WIDTH{1'b0}};
      fault       <= 1'b0;
      pll_reset   <= 1'b1;
      sys_reset   <= 1'b1;
      ready       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      retry_count <= retry_nxt_s;
      fault       <= fault_nxt_s;
      pll_reset   <= (state_nxt_s == RESET_PLL);
      sys_reset   <= (state_nxt_s != RUN);
      ready       <= (state_nxt_s == RUN);
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: a phase-level reference model
// predicts every cycle's outputs; a monitor compares them on the falling edge.
module tb_pll_reset_sequencer;

  localparam int RC   = 4;
  localparam int LT   = 20;
  localparam int SC   = 8;
  localparam int WD   = 16;
  localparam int CW   = 16;
  localparam int RW   = 4;
  localparam int RMAX = (1 << RW) - 1;
`ifdef PLL_HEARTBEAT_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic          refclk = 1'b0;
  logic          reset = 1'b1;
  logic          restart = 1'b0;
  logic          pll_lock = 1'b0;
  logic          heartbeat = 1'b0;
  logic          pll_reset;
  logic          sys_reset;
  logic          ready;
  logic [RW-1:0] retry_count;
  logic          fault;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit prst;
    bit srst;
    bit rdy;
    int retries;
    bit flt;
  } exp_t;

  exp_t sb[$];
  bit   hb_toggle_en = 1'b1;

  typedef enum {M_PULSE, M_WAIT, M_QUALIFY, M_RUN} mphase_e;
  mphase_e m_ph = M_PULSE;
  int      m_elapsed = 0;
  int      m_quiet = 0;
  int      m_retries = 0;
  bit      m_flt = 1'b0;
  bit      lk_hist[$];
  bit      hb_hist[$];

  pll_reset_sequencer #(
    .RESET_CYCLES    (RC),
    .LOCK_TIMEOUT    (LT),
    .SETTLE_CYCLES   (SC),
    .WATCHDOG_CYCLES (WD),
    .CNT_WIDTH       (CW),
    .RETRY_WIDTH     (RW)
  ) dut (
    .refclk      (refclk),
    .reset       (reset),
    .restart     (restart),
    .pll_lock    (pll_lock),
    .heartbeat   (heartbeat),
    .pll_reset   (pll_reset),
    .sys_reset   (sys_reset),
    .ready       (ready),
    .retry_count (retry_count),
    .fault       (fault)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: advance one refclk edge using the inputs just driven.
  task automatic model_step(output exp_t e);
    bit lock_seen;
    bit hb_edge;
    bit failed;
    failed = 1'b0;
    if (reset) begin
      m_ph      = M_PULSE;
      m_elapsed = 0;
      m_quiet   = 0;
      m_retries = 0;
      m_flt     = 1'b0;
      lk_hist   = '{1'b0, 1'b0};
      hb_hist   = '{1'b0, 1'b0, 1'b0};
    end else begin
      lock_seen = lk_hist[0];
      hb_edge   = hb_hist[0] ^ hb_hist[1];
      if (restart) begin
        m_ph      = M_PULSE;
        m_elapsed = 0;
        m_retries = 0;
        m_flt     = 1'b0;
      end else begin
        case (m_ph)
          M_PULSE: begin
            m_elapsed++;
            if (m_elapsed == RC) begin
              m_ph      = M_WAIT;
              m_elapsed = 0;
            end
          end
          M_WAIT: begin
            if (lock_seen) begin
              m_ph      = M_QUALIFY;
              m_elapsed = 0;
            end else begin
              m_elapsed++;
              if (m_elapsed == LT) failed = 1'b1;
            end
          end
          M_QUALIFY: begin
            if (!lock_seen) begin
              m_ph      = M_WAIT;
              m_elapsed = 0;
            end else begin
              m_elapsed++;
              if (m_elapsed == SC) begin
                m_ph    = M_RUN;
                m_quiet = 0;
              end
            end
          end
          default: begin
            if (!lock_seen) failed = 1'b1;
            else if (WD_ON && !hb_edge && m_quiet == WD - 1) failed = 1'b1;
            else m_quiet = hb_edge ? 0 : m_quiet + 1;
          end
        endcase
      end
      if (failed) begin
        m_ph      = M_PULSE;
        m_elapsed = 0;
        if (m_retries < RMAX) m_retries++;
        if (m_retries == RMAX) m_flt = 1'b1;
      end
      void'(lk_hist.pop_front());
      lk_hist.push_back(pll_lock);
      void'(hb_hist.pop_front());
      hb_hist.push_back(heartbeat);
    end
    e.prst    = (m_ph == M_PULSE);
    e.srst    = (m_ph != M_RUN);
    e.rdy     = (m_ph == M_RUN);
    e.retries = m_retries;
    e.flt     = m_flt;
  endtask

  // Drive one cycle of stimulus, predict the outcome, record it after the edge.
  task automatic cycle(input bit rst, input bit rs, input bit lk);
    exp_t e;
    @(negedge refclk);
    reset    = rst;
    restart  = rs;
    pll_lock = lk;
    if (hb_toggle_en && $urandom_range(0, 1) == 1) heartbeat = ~heartbeat;
    model_step(e);
    @(posedge refclk);
    sb.push_back(e);
  endtask

  task automatic hold(input int n, input bit lk);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, lk);
  endtask

  // Monitor: compare each cycle's outputs with the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge refclk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pll_reset", int'(pll_reset), int'(e.prst));
        check("sys_reset", int'(sys_reset), int'(e.srst));
        check("ready", int'(ready), int'(e.rdy));
        check("retry_count", int'(retry_count), e.retries);
        check("fault", int'(fault), int'(e.flt));
      end
    end
  end

  initial begin
    // Reset, then nominal bring-up with lock already high.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1);
    hold(40, 1'b1);
    // Lock loss in RUN, then lock held low across several timeouts.
    hold(5, 1'b0);
    hold(60, 1'b0);
    // Restart, then a 3-cycle lock dropout in the middle of SETTLE.
    cycle(1'b0, 1'b1, 1'b1);
    hold(8, 1'b1);
    hold(3, 1'b0);
    hold(40, 1'b1);
    // Heartbeat stops while running.
    hb_toggle_en = 1'b0;
    hold(60, 1'b1);
    hb_toggle_en = 1'b1;
    hold(20, 1'b1);
    // Restart with lock low long enough to saturate retries and set fault.
    cycle(1'b0, 1'b1, 1'b0);
    hold(16 * (RC + LT) + 10, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    hold(30, 1'b1);
    // Randomized lock segments, occasional restarts and heartbeat stalls.
    for (int seg = 0; seg < 60; seg++) begin
      bit lvl;
      int len;
      lvl          = ($urandom_range(0, 3) != 0);
      len          = $urandom_range(1, 40);
      hb_toggle_en = ($urandom_range(0, 5) != 0);
      for (int i = 0; i < len; i++) begin
        cycle(1'b0, ($urandom_range(0, 99) == 0), lvl);
      end
    end
    // Mid-run reset returns everything to the reset state.
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b1);
    hold(20, 1'b1);
    @(negedge refclk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
